imuldiv_mul_arbiter: RTL and testbench
======================================

Name: imuldiv_mul_arbiter

Overview:
Two-requester arbiter that shares one iterative multiplier (imuldiv_IntMulIterative val/rdy interface, single outstanding op) between two clients, e.g. two issue lanes.
- Selects one pending request by round-robin and forwards it to the multiplier.
- Records the owner and routes the 64-bit response back to that client only.
- Keeps saturating per-port grant counters for performance monitoring.
- Adds zero cycles of latency: forward and return paths are combinational through the arbiter.

Parameters:
W_CNT, 16, width of each per-port saturating grant counter (>=1)

Ports:
clk  in  1  clock
reset  in  1  reset
req0_msg_a  in  32  port 0 operand a
req0_msg_b  in  32  port 0 operand b
req0_val  in  1  port 0 request valid
req0_rdy  out  1  port 0 request ready
resp0_msg_result  out  64  port 0 product
resp0_val  out  1  port 0 response valid
resp0_rdy  in  1  port 0 response ready
req1_msg_a  in  32  port 1 operand a
req1_msg_b  in  32  port 1 operand b
req1_val  in  1  port 1 request valid
req1_rdy  out  1  port 1 request ready
resp1_msg_result  out  64  port 1 product
resp1_val  out  1  port 1 response valid
resp1_rdy  in  1  port 1 response ready
mulreq_msg_a  out  32  operand a to multiplier
mulreq_msg_b  out  32  operand b to multiplier
mulreq_val  out  1  request valid to multiplier
mulreq_rdy  in  1  multiplier ready
mulresp_msg_result  in  64  multiplier product
mulresp_val  in  1  multiplier response valid
mulresp_rdy  out  1  response ready to multiplier
grant_cnt0  out  W_CNT  saturating count of port 0 grants
grant_cnt1  out  W_CNT  saturating count of port 1 grants

Behaviour:
- Reset: reset, synchronous, active-high; clock clk.
- Registers on reset: state=IDLE, owner=0, prio=0 (port 0 preferred), grant_cnt0/1=0.
- While reset is high, mulreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val and mulresp_rdy are forced to 0.
- State IDLE:
  - grant0 = req0_val & (~req1_val | prio==0); grant1 = req1_val & ~grant0.
  - mulreq_val = req0_val | req1_val. mulreq_val never depends on mulreq_rdy.
  - mulreq_msg_a/b come from the granted port; when neither port is granted, they come from port 0.
  - reqN_rdy = grantN & mulreq_rdy.
  - On issue (mulreq_val & mulreq_rdy): owner <= granted port, grant_cntN += 1 (saturating at all-ones), state -> BUSY.
- State BUSY:
  - mulreq_val=0, req0_rdy=req1_rdy=0.
  - respN_val = mulresp_val & (owner==N); the non-owner resp_val stays 0.
  - resp0_msg_result = resp1_msg_result = mulresp_msg_result, unmodified.
  - mulresp_rdy = resp_rdy of the owner port.
  - On response handshake: prio <= ~owner (the port just served drops to low priority), state -> IDLE.
- A request arriving in the same cycle as a response handshake is not granted until the next cycle. This gives one idle cycle between back-to-back ops and is required behaviour.
- Backpressure: while the owner's resp_rdy is low, the arbiter holds its state and the multiplier holds its result. No other port is granted.
- A request valid that drops before its handshake has no effect on state. prio changes only on response handshake, never on request.
- Reset mid-operation (IDLE or BUSY): returns to IDLE and prio=0, and clears the counters. The multiplier shares the same reset. No response is delivered for the aborted op.
- Counters: grant_cntN is exactly W_CNT bits and holds at 2^W_CNT-1.
- Latency per op = multiplier latency + 0.

Decomposition:
- Shared include (imuldiv-MulArbDefs.v): STATE_IDLE=1'd0, STATE_BUSY=1'd1, PORT0=1'd0, PORT1=1'd1.
- One natural sub-module: imuldiv_MulArbRrPicker. It is combinational; inputs req0_val, req1_val, prio; outputs grant0, grant1. It is reusable by a future divider arbiter.
- Top level holds the FSM, the owner/prio registers, the counters and the muxing.

Test Plan:
- Port 0 only, 3*4, both resp_rdy=1 -> resp0_val with result 0x000000000000000C; resp1_val stays 0; grant_cnt0=1, grant_cnt1=0.
- Both ports continuously valid after reset, port 0 = 2*5, port 1 = -7*6 -> grants alternate 0,1,0,1. Port 0 receives 0x000000000000000A. Port 1 receives 0xFFFFFFFFFFFFFFD6. req1_rdy=0 while port 0 is in flight.
- Port 0 response with resp0_rdy low for 5 cycles, req1_val=1 -> resp0_val and the result hold stable for 5 cycles; req1_rdy=0 and mulreq_val=0 throughout; after the handshake, port 1 is issued the following cycle.
- Reset asserted for 1 cycle mid-BUSY on a port 1 op -> no resp1_val afterwards. Next simultaneous request grants port 0 (prio=0). Counters read 0 before that grant.
- W_CNT=2, five port 0 ops of 0x80000000*0x80000000 -> each result 0x4000000000000000; grant_cnt0 reads 1,2,3,3,3.
- mulreq_rdy held low in IDLE with req0_val=1 -> mulreq_val=1, req0_rdy=0, no state change; when mulreq_rdy rises, issue completes in that cycle.

Source files
------------

// File: rtl/imuldiv_mul_arbiter_pkg.sv
// Shared definitions for the two-port multiplier arbiter: FSM state encoding
// and port identifiers used for owner/priority tracking.
package imuldiv_mul_arbiter_pkg;

    typedef enum logic {
        STATE_IDLE = 1'b0,
        STATE_BUSY = 1'b1
    } state_e;

    localparam logic PORT0 = 1'b0;
    localparam logic PORT1 = 1'b1;

endpackage

// File: rtl/imuldiv_mul_arbiter_rr_picker.sv
// Combinational two-way round-robin picker; prio names the port that wins
// when both request in the same cycle.
module imuldiv_mul_arbiter_rr_picker
    import imuldiv_mul_arbiter_pkg::*;
(
    input  logic req0_val,
    input  logic req1_val,
    input  logic prio,
    output logic grant0,
    output logic grant1
);

    assign grant0 = req0_val & (~req1_val | (prio == PORT0));
    assign grant1 = req1_val & ~grant0;

endmodule

// File: rtl/imuldiv_mul_arbiter.sv
// Shares one single-outstanding iterative multiplier between two requesters;
// forward and return paths are combinational, so the arbiter adds no latency.
module imuldiv_mul_arbiter
    import imuldiv_mul_arbiter_pkg::*;
#(
    parameter int W_CNT = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [31:0]      req0_msg_a,
    input  logic [31:0]      req0_msg_b,
    input  logic             req0_val,
    output logic             req0_rdy,
    output logic [63:0]      resp0_msg_result,
    output logic             resp0_val,
    input  logic             resp0_rdy,

    input  logic [31:0]      req1_msg_a,
    input  logic [31:0]      req1_msg_b,
    input  logic             req1_val,
    output logic             req1_rdy,
    output logic [63:0]      resp1_msg_result,
    output logic             resp1_val,
    input  logic             resp1_rdy,

    output logic [31:0]      mulreq_msg_a,
    output logic [31:0]      mulreq_msg_b,
    output logic             mulreq_val,
    input  logic             mulreq_rdy,
    input  logic [63:0]      mulresp_msg_result,
    input  logic             mulresp_val,
    output logic             mulresp_rdy,

    output logic [W_CNT-1:0] grant_cnt0,
    output logic [W_CNT-1:0] grant_cnt1
);

    state_e           state;
    state_e           state_next;
    logic             owner;
    logic             prio;
    logic             grant0;
    logic             grant1;
    logic             issue;
    logic             resp_fire;
    logic [W_CNT-1:0] cnt0;
    logic [W_CNT-1:0] cnt1;

    imuldiv_mul_arbiter_rr_picker picker (
        .req0_val (req0_val),
        .req1_val (req1_val),
        .prio     (prio),
        .grant0   (grant0),
        .grant1   (grant1)
    );

    assign issue     = mulreq_val & mulreq_rdy;
    assign resp_fire = (state == STATE_BUSY) & mulresp_val & mulresp_rdy;

    always_ff @(posedge clk) begin
        if (reset) state <= STATE_IDLE;
        else       state <= state_next;
    end

    // A response handshake always lands in IDLE, so a request seen in the
    // same cycle waits one cycle before it can be granted.
    always_comb begin
        state_next = state;
        case (state)
            STATE_IDLE: if (issue)     state_next = STATE_BUSY;
            STATE_BUSY: if (resp_fire) state_next = STATE_IDLE;
            default:                   state_next = STATE_IDLE;
        endcase
    end

    always_comb begin
        mulreq_val  = 1'b0;
        req0_rdy    = 1'b0;
        req1_rdy    = 1'b0;
        resp0_val   = 1'b0;
        resp1_val   = 1'b0;
        mulresp_rdy = 1'b0;
        if (!reset) begin
            case (state)
                STATE_IDLE: begin
                    mulreq_val = req0_val | req1_val;
                    req0_rdy   = grant0 & mulreq_rdy;
                    req1_rdy   = grant1 & mulreq_rdy;
                end
                STATE_BUSY: begin
                    resp0_val   = mulresp_val & (owner == PORT0);
                    resp1_val   = mulresp_val & (owner == PORT1);
                    mulresp_rdy = (owner == PORT1) ? resp1_rdy : resp0_rdy;
                end
                default: ;
            endcase
        end
    end

    assign mulreq_msg_a     = grant1 ? req1_msg_a : req0_msg_a;
    assign mulreq_msg_b     = grant1 ? req1_msg_b : req0_msg_b;
    assign resp0_msg_result = mulresp_msg_result;
    assign resp1_msg_result = mulresp_msg_result;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner <= PORT0;
            prio  <= PORT0;
            cnt0  <= '0;
            cnt1  <= '0;
        end else begin
            if (issue) begin
                owner <= grant1 ? PORT1 : PORT0;
                if (grant0 && cnt0 != '1) cnt0 <= cnt0 + W_CNT'(1);
                if (grant1 && cnt1 != '1) cnt1 <= cnt1 + W_CNT'(1);
            end
            // The port just served drops to low priority.
            if (resp_fire) prio <= ~owner;
        end
    end

    assign grant_cnt0 = cnt0;
    assign grant_cnt1 = cnt1;

endmodule

// File: tb/tb_imuldiv_mul_arbiter.sv
// Bench for imuldiv_mul_arbiter: a behavioural multiplier, a round-robin
// reference model, directed vectors and randomized ops.
module tb_imuldiv_mul_arbiter;

    localparam int MUL_LAT = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] req0_msg_a, req0_msg_b, req1_msg_a, req1_msg_b;
    logic        req0_val, req1_val, resp0_rdy, resp1_rdy;
    logic        req0_rdy, req1_rdy, resp0_val, resp1_val;
    logic [63:0] resp0_msg_result, resp1_msg_result;
    logic [31:0] mulreq_msg_a, mulreq_msg_b;
    logic        mulreq_val, mulreq_rdy, mulresp_val, mulresp_rdy;
    logic [63:0] mulresp_msg_result;
    logic [15:0] grant_cnt0, grant_cnt1;

    // Second instance with 2-bit counters, fed the same inputs.
    logic        s_req0_rdy, s_req1_rdy, s_resp0_val, s_resp1_val;
    logic [63:0] s_resp0_res, s_resp1_res;
    logic [31:0] s_mul_a, s_mul_b;
    logic        s_mulreq_val, s_mulresp_rdy;
    logic [1:0]  s_cnt0, s_cnt1;

    always #5 clk = ~clk;

    imuldiv_mul_arbiter #(.W_CNT(16)) dut (
        .clk(clk), .reset(reset),
        .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(req0_rdy),
        .resp0_msg_result(resp0_msg_result), .resp0_val(resp0_val), .resp0_rdy(resp0_rdy),
        .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(req1_rdy),
        .resp1_msg_result(resp1_msg_result), .resp1_val(resp1_val), .resp1_rdy(resp1_rdy),
        .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val),
        .mulreq_rdy(mulreq_rdy), .mulresp_msg_result(mulresp_msg_result),
        .mulresp_val(mulresp_val), .mulresp_rdy(mulresp_rdy),
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
    );

    imuldiv_mul_arbiter #(.W_CNT(2)) dut_sat (
        .clk(clk), .reset(reset),
        .req0_msg_a(req0_msg_a), .req0_msg_b(req0_msg_b), .req0_val(req0_val), .req0_rdy(s_req0_rdy),
        .resp0_msg_result(s_resp0_res), .resp0_val(s_resp0_val), .resp0_rdy(resp0_rdy),
        .req1_msg_a(req1_msg_a), .req1_msg_b(req1_msg_b), .req1_val(req1_val), .req1_rdy(s_req1_rdy),
        .resp1_msg_result(s_resp1_res), .resp1_val(s_resp1_val), .resp1_rdy(resp1_rdy),
        .mulreq_msg_a(s_mul_a), .mulreq_msg_b(s_mul_b), .mulreq_val(s_mulreq_val),
        .mulreq_rdy(mulreq_rdy), .mulresp_msg_result(mulresp_msg_result),
        .mulresp_val(mulresp_val), .mulresp_rdy(s_mulresp_rdy),
        .grant_cnt0(s_cnt0), .grant_cnt1(s_cnt1)
    );

    function automatic logic [63:0] mul64(input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        sa = $signed(a);
        sb = $signed(b);
        return sa * sb;
    endfunction

    // Behavioural iterative multiplier: one op at a time, fixed latency,
    // result held until accepted.
    logic        mul_en;
    logic        mb_busy;
    int          mb_cnt;
    logic [63:0] mb_res;
    assign mulreq_rdy         = ~mb_busy & mul_en;
    assign mulresp_val        = mb_busy && mb_cnt == 0;
    assign mulresp_msg_result = mb_res;

    always @(posedge clk) begin
        if (reset) begin
            mb_busy <= 1'b0;
            mb_cnt  <= 0;
            mb_res  <= '0;
        end else if (!mb_busy) begin
            if (mulreq_val && mulreq_rdy) begin
                mb_busy <= 1'b1;
                mb_cnt  <= MUL_LAT;
                mb_res  <= mul64(mulreq_msg_a, mulreq_msg_b);
            end
        end else if (mb_cnt != 0) begin
            mb_cnt <= mb_cnt - 1;
        end else if (mulresp_rdy) begin
            mb_busy <= 1'b0;
        end
    end

    // Reference model state: who wins a tie, and grants per port.
    int ref_prio;
    int ref_cnt [2];
    int n_chk = 0;
    int n_fail = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic int sat3(input int v);
        return (v > 3) ? 3 : v;
    endfunction

    task automatic chk_counts();
        chk("grant_cnt0", grant_cnt0, ref_cnt[0]);
        chk("grant_cnt1", grant_cnt1, ref_cnt[1]);
        chk("sat_cnt0", s_cnt0, sat3(ref_cnt[0]));
        chk("sat_cnt1", s_cnt1, sat3(ref_cnt[1]));
    endtask

    // Called and returns just after a falling edge.
    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; req0_val = 1'b0; req1_val = 1'b0; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        ref_prio = 0; ref_cnt[0] = 0; ref_cnt[1] = 0;
        #1;
    endtask

    // One complete operation: issue, optional response backpressure, handshake,
    // then a look at the idle cycle that follows.
    task automatic op(input logic v0, input logic v1,
                      input logic [31:0] a0, input logic [31:0] b0,
                      input logic [31:0] a1, input logic [31:0] b1,
                      input int hold, output int got_port, output logic [63:0] got_res);
        int g, k;
        logic [63:0] exp;
        logic ov, xv;
        req0_val = v0; req0_msg_a = a0; req0_msg_b = b0;
        req1_val = v1; req1_msg_a = a1; req1_msg_b = b1;
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        #1;
        g = (v0 && v1) ? ref_prio : (v0 ? 0 : 1);
        k = 0;
        while (!(req0_rdy || req1_rdy) && k < 40) begin @(negedge clk); #1; k++; end
        chk("issue_timeout", k < 40, 1'b1);
        got_port = req1_rdy ? 1 : 0;
        chk("grant_port", got_port, g);
        chk("mulreq_val", mulreq_val, 1'b1);
        chk("mulreq_a", mulreq_msg_a, g ? a1 : a0);
        chk("mulreq_b", mulreq_msg_b, g ? b1 : b0);
        exp = g ? mul64(a1, b1) : mul64(a0, b0);
        @(posedge clk);
        ref_cnt[g]++;
        @(negedge clk);
        if (g == 0) req0_val = 1'b0; else req1_val = 1'b0;
        resp0_rdy = (g == 1); resp1_rdy = (g == 0);
        #1;
        chk_counts();
        k = 0;
        while (!(resp0_val || resp1_val) && k < 40) begin @(negedge clk); #1; k++; end
        chk("resp_timeout", k < 40, 1'b1);
        repeat (hold) begin
            ov = g ? resp1_val : resp0_val;
            chk("hold_val", ov, 1'b1);
            chk("hold_res", g ? resp1_msg_result : resp0_msg_result, exp);
            chk("hold_mulresp_rdy", mulresp_rdy, 1'b0);
            chk("hold_no_issue", {mulreq_val, req0_rdy, req1_rdy}, 3'b000);
            @(negedge clk); #1;
        end
        if (g == 0) resp0_rdy = 1'b1; else resp1_rdy = 1'b1;
        #1;
        ov = g ? resp1_val : resp0_val;
        xv = g ? resp0_val : resp1_val;
        got_res = g ? resp1_msg_result : resp0_msg_result;
        chk("resp_val", ov, 1'b1);
        chk("other_resp_val", xv, 1'b0);
        chk("resp_res", got_res, exp);
        chk("mulresp_rdy", mulresp_rdy, 1'b1);
        chk("busy_no_issue", {mulreq_val, req0_rdy, req1_rdy}, 3'b000);
        @(posedge clk);
        ref_prio = 1 - g;
        @(negedge clk);
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        #1;
        chk("next_issue", {req1_rdy, req0_rdy},
            {(g == 0) && req1_val && mul_en, (g == 1) && req0_val && mul_en});
    endtask

    typedef struct {
        logic        rst;
        logic        v0, v1;
        logic [31:0] a0, b0, a1, b1;
        int          hold;
        int          port;
        logic [63:0] res;
    } vec_t;

    vec_t tbl [7];

    initial begin
        int          gp;
        logic [63:0] gr;
        logic        seen;
        logic [1:0]  sat_exp [5];
        logic        v0, v1;

        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int          gp;
        logic [63:0] gr;
        logic        seen;
        logic [1:0]  sat_exp [5];
        logic        v0, v1;

        tbl[0] = '{1'b1, 1'b1, 1'b0, 32'd3, 32'd4, 32'd0, 32'd0, 0, 0, 64'h000000000000000C};
        tbl[1] = '{1'b1, 1'b1, 1'b1, 32'd2, 32'd5, -32'sd7, 32'd6, 0, 0, 64'h000000000000000A};
        tbl[2] = '{1'b0, 1'b1, 1'b1, 32'd2, 32'd5, -32'sd7, 32'd6, 0, 1, 64'hFFFFFFFFFFFFFFD6};
        tbl[3] = '{1'b0, 1'b1, 1'b1, 32'd2, 32'd5, -32'sd7, 32'd6, 0, 0, 64'h000000000000000A};
        tbl[4] = '{1'b0, 1'b1, 1'b1, 32'd2, 32'd5, -32'sd7, 32'd6, 0, 1, 64'hFFFFFFFFFFFFFFD6};
        tbl[5] = '{1'b0, 1'b1, 1'b1, 32'd2, 32'd5, -32'sd7, 32'd6, 5, 0, 64'h000000000000000A};
        tbl[6] = '{1'b0, 1'b1, 1'b1, 32'd2, 32'd5, -32'sd7, 32'd6, 0, 1, 64'hFFFFFFFFFFFFFFD6};
        sat_exp[0] = 2'd1; sat_exp[1] = 2'd2; sat_exp[2] = 2'd3; sat_exp[3] = 2'd3; sat_exp[4] = 2'd3;

        mul_en = 1'b1;
        reset = 1'b1;
        req0_val = 1'b0; req1_val = 1'b0; resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        req0_msg_a = '0; req0_msg_b = '0; req1_msg_a = '0; req1_msg_b = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        ref_prio = 0; ref_cnt[0] = 0; ref_cnt[1] = 0;
        #1;
        chk_counts();
        chk("reset_idle_outs", {mulreq_val, resp0_val, resp1_val, mulresp_rdy}, 4'b0000);

        // Directed vectors.
        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset();
            op(tbl[i].v0, tbl[i].v1, tbl[i].a0, tbl[i].b0, tbl[i].a1, tbl[i].b1,
               tbl[i].hold, gp, gr);
            chk($sformatf("vec%0d_port", i), gp, tbl[i].port);
            chk($sformatf("vec%0d_res", i), gr, tbl[i].res);
        end

        // Reset in the middle of a port 1 op.
        do_reset();
        req1_val = 1'b1; req1_msg_a = 32'd11; req1_msg_b = 32'd13;
        #1;
        chk("rst_issue1", req1_rdy, 1'b1);
        @(negedge clk);
        req1_val = 1'b0;
        @(negedge clk);
        reset = 1'b1; req0_val = 1'b1; req1_val = 1'b1; resp0_rdy = 1'b1; resp1_rdy = 1'b1;
        #1;
        chk("rst_forced", {mulreq_val, req0_rdy, req1_rdy, resp0_val, resp1_val, mulresp_rdy}, 6'b0);
        @(negedge clk);
        reset = 1'b0; req0_val = 1'b0; req1_val = 1'b0;
        ref_prio = 0; ref_cnt[0] = 0; ref_cnt[1] = 0;
        #1;
        chk_counts();
        seen = 1'b0;
        repeat (8) begin
            seen = seen | resp1_val | resp0_val;
            @(negedge clk); #1;
        end
        chk("rst_no_resp", seen, 1'b0);
        resp0_rdy = 1'b0; resp1_rdy = 1'b0;
        op(1'b1, 1'b1, 32'd4, 32'd4, 32'd9, 32'd9, 0, gp, gr);
        chk("rst_then_port0", gp, 0);

        // Multiplier not ready: request waits, a dropped request leaves no trace.
        mul_en = 1'b0;
        req1_val = 1'b1; req1_msg_a = 32'd1; req1_msg_b = 32'd1;
        repeat (2) begin
            #1;
            chk("stall1_val", {mulreq_val, req1_rdy}, 2'b10);
            @(negedge clk);
        end
        req1_val = 1'b0;
        req0_val = 1'b1; req0_msg_a = 32'd7; req0_msg_b = 32'd9;
        repeat (3) begin
            #1;
            chk("stall0_val", {mulreq_val, req0_rdy}, 2'b10);
            @(negedge clk);
        end
        #1;
        chk_counts();
        mul_en = 1'b1;
        #1;
        chk("stall_release", req0_rdy, 1'b1);
        op(1'b1, 1'b0, 32'd7, 32'd9, 32'd0, 32'd0, 0, gp, gr);
        chk("stall_res", gr, 64'd63);

        // Saturation of the 2-bit counter instance.
        do_reset();
        for (int i = 0; i < 5; i++) begin
            op(1'b1, 1'b0, 32'h80000000, 32'h80000000, 32'd0, 32'd0, 0, gp, gr);
            chk("sat_res", gr, 64'h4000000000000000);
            chk($sformatf("sat_cnt_seq%0d", i), s_cnt0, sat_exp[i]);
        end

        // Randomized ops against the reference model.
        for (int i = 0; i < 40; i++) begin
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            op(v0, v1, $urandom, $urandom, $urandom, $urandom, $urandom_range(0, 2), gp, gr);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
